spike_rate_decoder: RTL

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Measures a neuron spike train over one window of W cycles. The window
//   starts with i_start. The result is held until i_ready accepts it.
//   Results: the spike count (saturating), the window index of the first
//   spike, and the minimum inter-spike interval.
//
// Ports
//   i_clk, i_rst       clock (rising edge), synchronous active-high reset
//   i_start, i_window  start a window of i_window cycles (0 is ignored)
//   i_spike            spike bit, sampled once per cycle while counting
//   i_ready            consumer accepts the result
//   o_busy             high while counting or holding a result
//   o_valid            result valid
//   o_count            spikes counted in the window
//   o_first_lat        window index of the first spike (all ones if none)
//   o_isi_min          minimum inter-spike interval (all ones if < 2 spikes)
module spike_rate_decoder #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_window,
  input  logic             i_spike,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count,
  output logic [WIN_W-1:0] o_first_lat,
  output logic [WIN_W-1:0] o_isi_min
);

  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;

  state_t           state, state_nx;
  logic [WIN_W-1:0] win_len;
  logic [WIN_W-1:0] t;
  logic [WIN_W-1:0] last_t;
  logic [WIN_W-1:0] first_lat;
  logic [WIN_W-1:0] isi_min;
  logic [CNT_W-1:0] count;
  logic             have_first;

  logic             start_ok;
  logic             last_sample;
  logic [WIN_W-1:0] isi;

  assign start_ok    = (state == IDLE) && i_start && (i_window != '0);
  // win_len is never 0 while counting, so win_len-1 cannot wrap.
  assign last_sample = (t == win_len - WIN_W'(1));
  // t is strictly greater than last_t whenever this is used.
  assign isi         = t - last_t;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = COUNT;
      COUNT:   if (last_sample) state_nx = REPORT;
      REPORT:  if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy  = 1'b0;
    o_valid = 1'b0;
    case (state)
      COUNT:   o_busy = 1'b1;
      REPORT: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Window datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_len    <= '0;
      t          <= '0;
      last_t     <= '0;
      first_lat  <= '0;
      isi_min    <= '0;
      count      <= '0;
      have_first <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          win_len    <= i_window;
          t          <= '0;
          last_t     <= '0;
          count      <= '0;
          // All ones means "no spike" / "no interval" if nothing updates them.
          first_lat  <= '1;
          isi_min    <= '1;
          have_first <= 1'b0;
        end
        COUNT: begin
          // t ends at W; for W = 2^WIN_W-1 that is still representable.
          t <= t + WIN_W'(1);
          if (i_spike) begin
            if (count != '1) count <= count + CNT_W'(1);
            if (!have_first) begin
              first_lat  <= t;
              have_first <= 1'b1;
            end else if (isi < isi_min) begin
              isi_min <= isi;
            end
            last_t <= t;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count     = count;
  assign o_first_lat = first_lat;
  assign o_isi_min   = isi_min;

endmodule
